// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller.
package mux_scan_pkg;
  localparam int unsigned NCH  = 8;
  localparam int unsigned SELW = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SAMPLE,
    DONE
  } state_t;
endpackage

// File: rtl/mux_scan_next.sv
// Finds the lowest set mask bit strictly above idx; from_start searches from bit 0 inclusive.
module mux_scan_next
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] idx,
  input  logic            from_start,
  output logic [SELW-1:0] nxt,
  output logic            found
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && mask[i] && (from_start || (i > 32'(idx)))) begin
        found = 1'b1;
        nxt   = i[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctl.sv
// Scans enabled mux channels (LOAD then SAMPLE per channel) and captures y into status.
// Optional interrupt output enabled by defining MUX_SCAN_CTL_IRQ_EN.
module mux_scan_ctl
  import mux_scan_pkg::*;
(
  input  logic            clk,
  input  logic            clr_,
  input  logic            start,
  input  logic [NCH-1:0]  mask,
  input  logic            pol_in,
  input  logic            y,
`ifdef MUX_SCAN_CTL_IRQ_EN
  input  logic            irq_ack,
  output logic            irq,
`endif
  output logic [SELW-1:0] sel,
  output logic            pol,
  output logic            re_,
  output logic            me_,
  output logic            oe_,
  output logic            busy,
  output logic            done,
  output logic [NCH-1:0]  status
);

  state_t          state_q, state_d;
  logic [NCH-1:0]  mask_q;
  logic [SELW-1:0] sel_q;
  logic            pol_q;
  logic [NCH-1:0]  status_q;

  logic [SELW-1:0] first_idx, next_idx;
  logic            first_found, next_found;

  mux_scan_next u_first (
    .mask       (mask),
    .idx        ('0),
    .from_start (1'b1),
    .nxt        (first_idx),
    .found      (first_found)
  );

  mux_scan_next u_next (
    .mask       (mask_q),
    .idx        (sel_q),
    .from_start (1'b0),
    .nxt        (next_idx),
    .found      (next_found)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = first_found ? LOAD : DONE;
      LOAD:    state_d = SAMPLE;
      SAMPLE:  state_d = next_found ? LOAD : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sel/pol only move when a channel is actually loaded, so they hold between scans
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      sel_q    <= '0;
      pol_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            status_q <= '0;
            mask_q   <= mask;
            if (first_found) begin
              sel_q <= first_idx;
              pol_q <= pol_in;
            end
          end
        end
        SAMPLE: begin
          status_q[sel_q] <= y;
          if (next_found) sel_q <= next_idx;
        end
        default: ;
      endcase
    end
  end

`ifdef MUX_SCAN_CTL_IRQ_EN
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_)                                irq <= 1'b0;
    else if (state_q == DONE && status_q != '0) irq <= 1'b1;
    else if (irq_ack)                         irq <= 1'b0;
  end
`endif

  assign sel    = sel_q;
  assign pol    = pol_q;
  assign re_    = (state_q != LOAD);
  assign me_    = (state_q != SAMPLE);
  assign oe_    = (state_q != SAMPLE);
  assign busy   = (state_q == LOAD) || (state_q == SAMPLE);
  assign done   = (state_q == DONE);
  assign status = status_q;

endmodule

// File: tb/tb_mux_scan_ctl.sv
// Scoreboard bench for mux_scan_ctl: stimulus queues expected scans and loads, a monitor checks them.
module tb_mux_scan_ctl;
  import mux_scan_pkg::*;

  logic       clk = 1'b0;
  logic       clr_, start, pol_in, y;
  logic [7:0] mask, dval;
  logic [2:0] sel;
  logic       pol, re_, me_, oe_, busy, done;
  logic [7:0] status;
`ifdef MUX_SCAN_CTL_IRQ_EN
  logic       irq_ack, irq;
`endif

  mux_scan_ctl dut (
    .clk     (clk),
    .clr_    (clr_),
    .start   (start),
    .mask    (mask),
    .pol_in  (pol_in),
    .y       (y),
`ifdef MUX_SCAN_CTL_IRQ_EN
    .irq_ack (irq_ack),
    .irq     (irq),
`endif
    .sel     (sel),
    .pol     (pol),
    .re_     (re_),
    .me_     (me_),
    .oe_     (oe_),
    .busy    (busy),
    .done    (done),
    .status  (status)
  );

  always #5 clk = ~clk;

  // mux model: output valid only while enabled, inverted by pol
  assign y = (!me_ && !oe_) ? (dval[sel] ^ pol) : 1'b0;

  typedef struct {
    logic [7:0] status;
    int         done_cyc;
    int         busy_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] load_q[$];
  int         checks = 0, errors = 0;
  int         edge_cnt = 0, s_edge = 0, busy_cnt = 0;
  exp_t       ee;
  logic [3:0] le;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!clr_) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      else chk("idle_ctl", {29'd0, re_, me_, oe_}, 32'd7);
      if (!re_) begin
        if (load_q.size() == 0) begin
          errors++;
          $display("FAIL load: unexpected load sel=%0d expected none", sel);
        end else begin
          le = load_q.pop_front();
          chk("load_pol_sel", {28'd0, pol, sel}, {28'd0, le});
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done: unexpected done pulse got 1 expected 0");
        end else begin
          ee = exp_q.pop_front();
          chk("status", {24'd0, status}, {24'd0, ee.status});
          chk("done_cycle", edge_cnt - s_edge, ee.done_cyc);
          chk("busy_cycles", busy_cnt, ee.busy_cyc);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] m, input logic p, input logic [7:0] d,
                       input logic [7:0] st, input int dc, input int bc);
    @(negedge clk);
    mask = m; pol_in = p; dval = d; start = 1'b1;
    exp_q.push_back('{st, dc, bc});
    for (int k = 0; k < 8; k++)
      if (m[k]) load_q.push_back({p, 3'(k)});
    @(posedge clk);
    s_edge = edge_cnt;
    #1 start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    #1;
    chk("scan_complete", exp_q.size(), 0);
    chk("loads_all", load_q.size(), 0);
    exp_q.delete();
    load_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    clr_ = 1'b0; start = 1'b0; mask = '0; pol_in = 1'b0; dval = '0;
`ifdef MUX_SCAN_CTL_IRQ_EN
    irq_ack = 1'b0;
`endif
    #12;
    chk("rst_sel", {29'd0, sel}, 0);
    chk("rst_pol", {31'd0, pol}, 0);
    chk("rst_ctl", {29'd0, re_, me_, oe_}, 32'd7);
    chk("rst_busy_done", {30'd0, busy, done}, 0);
    chk("rst_status", {24'd0, status}, 0);
    @(negedge clk) clr_ = 1'b1;

    // full scan
    issue(8'hFF, 1'b0, 8'hA5, 8'hA5, 17, 16);
    drain(40);

    // sparse scan with inverted polarity
    issue(8'h12, 1'b1, 8'h00, 8'h12, 5, 4);
    drain(40);
    repeat (3) @(negedge clk);
    chk("status_hold", {24'd0, status}, 32'h12);

    // empty mask: no mux access, status cleared, sel/pol untouched
    issue(8'h00, 1'b0, 8'hFF, 8'h00, 1, 0);
    drain(20);
    chk("sel_hold", {29'd0, sel}, 4);
    chk("pol_hold", {31'd0, pol}, 1);

    // restart attempt mid-scan with a different mask
    issue(8'h81, 1'b0, 8'h81, 8'h81, 5, 4);
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1; mask = 8'hFF; pol_in = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mask = 8'h00; pol_in = 1'b0;
    drain(40);

    // asynchronous clear in cycle 6 of a full scan
    issue(8'hFF, 1'b1, 8'h00, 8'hFF, 17, 16);
    repeat (6) @(negedge clk);
    exp_q.delete();
    load_q.delete();
    #1 clr_ = 1'b0;
    #1;
    chk("abort_sel", {29'd0, sel}, 0);
    chk("abort_pol", {31'd0, pol}, 0);
    chk("abort_ctl", {29'd0, re_, me_, oe_}, 32'd7);
    chk("abort_busy_done", {30'd0, busy, done}, 0);
    chk("abort_status", {24'd0, status}, 0);
`ifdef MUX_SCAN_CTL_IRQ_EN
    chk("abort_irq", {31'd0, irq}, 0);
`endif
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 clr_ = 1'b1;
    issue(8'hFF, 1'b0, 8'h3C, 8'h3C, 17, 16);
    drain(40);

`ifdef MUX_SCAN_CTL_IRQ_EN
    irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    chk("irq_cleared", {31'd0, irq}, 0);
    issue(8'h04, 1'b0, 8'h04, 8'h04, 3, 2);
    drain(20);
    @(negedge clk);
    chk("irq_set", {31'd0, irq}, 1);
    irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    chk("irq_ack", {31'd0, irq}, 0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
